mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-stage consumer of the EX/MEM pipeline register in the five-stage RISC-V core. It turns each EX/MEM entry into a data-bus transaction with a request/acknowledge handshake. It applies byte-lane steering and load sign/zero extension, stalls the upstream pipeline while a transaction is outstanding, and registers the MEM/WB pipeline outputs.

## Interface
Parameters:
- none (XLEN fixed at 32)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- MemRead  in  1  EX/MEM: load
- MemWrite  in  1  EX/MEM: store
- MemtoReg  in  1  EX/MEM: writeback selects load data
- RegWrite  in  1  EX/MEM: register write enable
- ALU  in  32  EX/MEM: effective address / ALU result
- rd2  in  32  EX/MEM: store data
- inst3  in  5  EX/MEM: destination register
- funct3  in  3  EX/MEM: access size/sign
- bus_req  out  1  transaction request (registered)
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {ALU[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  one-cycle completion
- stall  out  1  hold PC/IF/ID/EX and EX/MEM (combinational)
- misalign  out  1  one-cycle misaligned-access pulse (only with MISALIGN_TRAP_EN)
- RegWrite_wb, MemtoReg_wb  out  1 each  MEM/WB controls
- rdata_wb  out  32  extended load data
- ALU_wb  out  32  ALU result passthrough
- inst3_wb  out  5  destination register

## Operation
- mem_op = MemRead | MemWrite. If both are set, the access is a load.
- The FSM has two states, IDLE and BUSY.
  - IDLE → BUSY on a clock edge with mem_op high (and not trapped). At that edge, bus_req/bus_we/bus_addr/bus_be/bus_wdata are registered.
  - BUSY holds all bus outputs stable until bus_ack. On a bus_ack edge: BUSY → IDLE, bus_req ← 0.
  - bus_ack in IDLE is ignored.
- stall = mem_op & ~(BUSY & bus_ack).
- Store lanes use a = ALU[1:0]:
  - SB (000): be = 4'b0001<<a, wdata = {4{rd2[7:0]}}
  - SH (001): be = 4'b0011<<{a[1],1'b0}, wdata = {2{rd2[15:0]}}
  - SW (010) and any other funct3: be = 4'b1111, wdata = rd2
  - Loads drive be = 4'b1111.
- Load extract selects the byte or halfword at a:
  - LB (000): sign-extend byte
  - LH (001): sign-extend halfword
  - LBU (100): zero-extend byte
  - LHU (101): zero-extend halfword
  - LW (010) and others: full word
- MEM/WB register rules:
  - Non-mem op with stall low: loaded every edge from inputs; rdata_wb ← 0.
  - Memory op: loaded at the ack edge, with rdata_wb ← extended bus_rdata for loads and 0 for stores.
  - While stall is high: RegWrite_wb ← 0 (bubble) and the other MEM/WB fields hold.

## Timing
- Reset (async, immediate) sets:
  - state IDLE
  - bus_req, bus_we = 0; bus_addr, bus_be, bus_wdata = 0
  - all *_wb outputs = 0
  - misalign = 0
- Reset asserted in BUSY abandons the transaction immediately; bus_req drops without waiting for ack.
- Memory access minimum is 2 cycles. Cycle 0 has stall high. bus_req is high from cycle 1. If ack arrives in cycle 1, stall is low in cycle 1 and MEM/WB updates at the end of cycle 1.
- Each extra wait cycle of the slave adds one stall cycle.
- Back-to-back memory ops: after the ack edge the FSM is in IDLE. The next op raises bus_req one edge later, so bus_req is low for one cycle between transactions.
- Non-memory instructions: 1-cycle latency, no stall.

## Configuration
- MISALIGN_TRAP_EN:
  - Defined: a misaligned memory op is trapped. Misaligned means halfword with ALU[0]=1, or word with ALU[1:0]≠0.
    - No bus transaction and no stall.
    - misalign pulses for one cycle (registered, the cycle after the edge).
    - The instruction enters MEM/WB with RegWrite_wb=0.
  - Undefined: the misalign port is tied 0 and the offending low address bits are ignored for lane selection:
    - halfword uses a[1]
    - word uses lanes 1111

## Test plan
- Reset mid-BUSY: assert rst_n=0 with bus_req=1 → bus_req=0, state IDLE and all *_wb=0 in the same cycle. On release with no mem op → stall=0.
- SW rd2=0xDEADBEEF, ALU=0x100, slave acks after 3 wait cycles → bus_addr=0x100, be=1111, wdata=0xDEADBEEF, stall high for 4 cycles, RegWrite_wb=0 during stall.
- SB rd2=0x000000A5, ALU=0x203 → be=1000, wdata=0xA5A5A5A5, bus_addr=0x200.
- LB at 0x301 with bus_rdata=0x1234F600, inst3=7 → rdata_wb=0xFFFFFFF6, inst3_wb=7, MemtoReg_wb=1. The same access as LBU gives rdata_wb=0x000000F6.
- ADD result 0x55 then LW with same-cycle ack, back-to-back → ALU_wb=0x55 after 1 cycle, no stall, then LW completes with exactly 1 stall cycle.
- With MISALIGN_TRAP_EN: LH at 0x401 → no bus_req, misalign=1 for one cycle, RegWrite_wb=0. Without the macro: bus_be=0011 and no pulse.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: EX/MEM to data-bus request/ack stage with lane steering, load extension and MEM/WB register.
// Define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
module mem_access_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic [31:0] ALU,
  input  logic [31:0] rd2,
  input  logic [4:0]  inst3,
  input  logic [2:0]  funct3,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall,
  output logic        misalign,
  output logic        RegWrite_wb,
  output logic        MemtoReg_wb,
  output logic [31:0] rdata_wb,
  output logic [31:0] ALU_wb,
  output logic [4:0]  inst3_wb
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state;
  logic w_mem_op, w_byte, w_half, w_trap, w_ack;
  logic [1:0] w_a;
  logic [3:0] w_be;
  logic [7:0] w_b;
  logic [15:0] w_h;
  logic [31:0] w_wdata, w_ext;
  assign w_mem_op = MemRead | MemWrite;
  assign w_a = ALU[1:0];
  // Loads decode size from funct3[1:0] (bit 2 is unsigned); stores only know SB/SH, everything else is a word.
  assign w_byte = MemRead ? funct3[1:0] == 2'b00 : funct3 == 3'b000;
  assign w_half = MemRead ? funct3[1:0] == 2'b01 : funct3 == 3'b001;
`ifdef MISALIGN_TRAP_EN
  logic r_mis;
  assign w_trap = w_mem_op & ((w_half & w_a[0]) | (~w_byte & ~w_half & (w_a != 2'b00)));
  assign misalign = r_mis;
`else
  assign w_trap = 1'b0;
  assign misalign = 1'b0;
`endif
  assign w_ack = (r_state == BUSY) & bus_ack;
  assign stall = w_mem_op & ~w_trap & ~w_ack;
  assign w_be = MemRead ? 4'hf : w_byte ? 4'b0001 << w_a : w_half ? 4'b0011 << {w_a[1], 1'b0} : 4'hf;
  assign w_wdata = w_byte ? {4{rd2[7:0]}} : w_half ? {2{rd2[15:0]}} : rd2;
  assign w_b = bus_rdata[{w_a, 3'b000} +: 8];
  assign w_h = w_a[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  assign w_ext = w_byte ? {{24{~funct3[2] & w_b[7]}}, w_b} :
                 w_half ? {{16{~funct3[2] & w_h[15]}}, w_h} : bus_rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      RegWrite_wb <= 1'b0;
      MemtoReg_wb <= 1'b0;
      rdata_wb    <= '0;
      ALU_wb      <= '0;
      inst3_wb    <= '0;
`ifdef MISALIGN_TRAP_EN
      r_mis       <= 1'b0;
`endif
    end else begin
      if (r_state == IDLE && w_mem_op && !w_trap) begin
        r_state   <= BUSY;
        bus_req   <= 1'b1;
        bus_we    <= ~MemRead;
        bus_addr  <= {ALU[31:2], 2'b00};
        bus_be    <= w_be;
        bus_wdata <= w_wdata;
      end else if (w_ack) begin
        r_state <= IDLE;
        bus_req <= 1'b0;
      end
      RegWrite_wb <= RegWrite & ~stall & ~w_trap;
      if (!stall) begin
        MemtoReg_wb <= MemtoReg;
        ALU_wb      <= ALU;
        inst3_wb    <= inst3;
        rdata_wb    <= (MemRead & ~w_trap) ? w_ext : 32'h0;
      end
`ifdef MISALIGN_TRAP_EN
      r_mis <= w_trap;
`endif
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized and directed checks of mem_access_stage against a transaction-level model.
module tb_mem_access_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic MemRead = 0, MemWrite = 0, MemtoReg = 0, RegWrite = 0, bus_ack = 0;
  logic [31:0] ALU = 0, rd2 = 0, bus_rdata = 0;
  logic [4:0] inst3 = 0;
  logic [2:0] funct3 = 0;
  logic bus_req, bus_we, stall, misalign, RegWrite_wb, MemtoReg_wb;
  logic [31:0] bus_addr, bus_wdata, rdata_wb, ALU_wb;
  logic [3:0] bus_be;
  logic [4:0] inst3_wb;
  int checks = 0, failures = 0, obs_stalls;
  logic [3:0] obs_be;
  logic [31:0] obs_addr, obs_wdata;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALU(ALU), .rd2(rd2), .inst3(inst3), .funct3(funct3),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .stall(stall),
    .misalign(misalign), .RegWrite_wb(RegWrite_wb), .MemtoReg_wb(MemtoReg_wb),
    .rdata_wb(rdata_wb), .ALU_wb(ALU_wb), .inst3_wb(inst3_wb));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic int sz(input logic ld, input logic [2:0] f3);
    if (ld) return (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
    return f3 == 0 ? 1 : f3 == 1 ? 2 : 4;
  endfunction

  function automatic logic [3:0] exp_be(input logic ld, input logic [2:0] f3, input logic [31:0] addr);
    int s = sz(ld, f3);
    if (ld || s == 4) return 4'hf;
    if (s == 1) return 4'(1 << addr[1:0]);
    return 4'(3 << (2 * addr[1]));
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] d);
    int s = sz(1'b0, f3);
    if (s == 1) return (d & 32'hff) * 32'h01010101;
    if (s == 2) return (d & 32'hffff) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] r);
    int s = sz(1'b1, f3);
    logic [31:0] v;
    if (s == 1) begin
      v = (r >> (8 * addr[1:0])) & 32'hff;
      if (f3 == 0 && v >= 32'h80) v = v - 32'h100;
      return v;
    end
    if (s == 2) begin
      v = (r >> (16 * addr[1])) & 32'hffff;
      if (f3 == 1 && v >= 32'h8000) v = v - 32'h10000;
      return v;
    end
    return r;
  endfunction

  function automatic logic mis(input logic ld, input logic [2:0] f3, input logic [31:0] addr);
    int s = sz(ld, f3);
    return (s == 2 && addr[0]) || (s == 4 && addr[1:0] != 0);
  endfunction

  // One instruction: the bench acts as both upstream pipeline and slave, acking after `waits` extra cycles.
  task automatic run(input logic rd, input logic wr, input logic m2r, input logic rw,
                     input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] rdst,
                     input logic [2:0] f3, input int waits, input logic [31:0] rdata);
    logic mem, trap;
    int n;
    mem = rd | wr;
`ifdef MISALIGN_TRAP_EN
    trap = mem && mis(rd, f3, alu);
`else
    trap = 1'b0;
`endif
    n = (mem && !trap) ? 2 + waits : 1;
    obs_stalls = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      MemRead = rd; MemWrite = wr; MemtoReg = m2r; RegWrite = rw;
      ALU = alu; rd2 = d2; inst3 = rdst; funct3 = f3;
      bus_ack = (n > 1 && c == n - 1) || (c == 0 && $urandom_range(0, 1) == 1);
      bus_rdata = (c == n - 1) ? rdata : $urandom;
      #1;
      chk("stall", stall, n > 1 && c != n - 1);
      if (stall) obs_stalls++;
      chk("bus_req", bus_req, c >= 1);
      if (c >= 1) begin
        chk("bus_addr", bus_addr, alu & ~32'h3);
        chk("bus_be", bus_be, exp_be(rd, f3, alu));
        chk("bus_we", bus_we, wr & ~rd);
        if (wr && !rd) chk("bus_wdata", bus_wdata, exp_wd(f3, d2));
        obs_be = bus_be; obs_addr = bus_addr; obs_wdata = bus_wdata;
      end
      @(posedge clk);
      #1;
      chk("misalign", misalign, trap && c == n - 1);
      if (c != n - 1) chk("wb_bubble", RegWrite_wb, 0);
      else begin
        chk("RegWrite_wb", RegWrite_wb, rw & ~trap);
        chk("MemtoReg_wb", MemtoReg_wb, m2r);
        chk("ALU_wb", ALU_wb, alu);
        chk("inst3_wb", inst3_wb, rdst);
        chk("rdata_wb", rdata_wb, (rd && !trap) ? exp_ld(f3, alu, rdata) : 32'h0);
        if (trap) chk("trap_no_req", bus_req, 0);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_rw_wb", RegWrite_wb, 0);
    chk("rst_alu_wb", ALU_wb, 0);
    chk("rst_rdata_wb", rdata_wb, 0);
    chk("rst_misalign", misalign, 0);
    @(negedge clk) rst_n = 1'b1;
    // ADD then LW with same-cycle ack
    run(0, 0, 0, 1, 32'h55, 0, 5'd3, 3'b000, 0, 0);
    chk("add_alu_wb_lit", ALU_wb, 32'h55);
    run(1, 0, 1, 1, 32'h80, 0, 5'd4, 3'b010, 0, 32'hCAFEF00D);
    chk("lw_stalls_lit", obs_stalls, 1);
    chk("lw_rdata_lit", rdata_wb, 32'hCAFEF00D);
    run(0, 1, 0, 0, 32'h100, 32'hDEADBEEF, 5'd0, 3'b010, 3, 0);
    chk("sw_stalls_lit", obs_stalls, 4);
    chk("sw_addr_lit", obs_addr, 32'h100);
    chk("sw_be_lit", obs_be, 4'b1111);
    chk("sw_wdata_lit", obs_wdata, 32'hDEADBEEF);
    run(0, 1, 0, 0, 32'h203, 32'h000000A5, 5'd0, 3'b000, 1, 0);
    chk("sb_addr_lit", obs_addr, 32'h200);
    chk("sb_be_lit", obs_be, 4'b1000);
    chk("sb_wdata_lit", obs_wdata, 32'hA5A5A5A5);
    run(1, 0, 1, 1, 32'h301, 0, 5'd7, 3'b000, 2, 32'h1234F600);
    chk("lb_rdata_lit", rdata_wb, 32'hFFFFFFF6);
    chk("lb_inst3_lit", inst3_wb, 5'd7);
    chk("lb_m2r_lit", MemtoReg_wb, 1);
    run(1, 0, 1, 1, 32'h301, 0, 5'd7, 3'b100, 0, 32'h1234F600);
    chk("lbu_rdata_lit", rdata_wb, 32'h000000F6);
`ifdef MISALIGN_TRAP_EN
    run(1, 0, 1, 1, 32'h401, 0, 5'd9, 3'b001, 0, 0);
    chk("lh_mis_rw_lit", RegWrite_wb, 0);
    chk("lh_mis_pulse_lit", misalign, 1);
    run(0, 0, 0, 0, 32'h0, 0, 5'd0, 3'b000, 0, 0);
    chk("lh_mis_drop_lit", misalign, 0);
`else
    run(0, 1, 0, 0, 32'h401, 32'h00001234, 5'd0, 3'b001, 0, 0);
    chk("sh_be_lit", obs_be, 4'b0011);
    chk("sh_wdata_lit", obs_wdata, 32'h12341234);
    run(1, 0, 1, 1, 32'h401, 0, 5'd9, 3'b001, 0, 32'hABCD1234);
    chk("lh_rdata_lit", rdata_wb, 32'h00001234);
    chk("lh_no_pulse_lit", misalign, 0);
`endif
    // Reset asserted while a store is waiting for ack
    @(negedge clk);
    MemRead = 0; MemWrite = 1; RegWrite = 0; ALU = 32'h500; rd2 = 32'h1; funct3 = 3'b010; bus_ack = 0;
    @(negedge clk);
    #1;
    chk("busy_req", bus_req, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstb_bus_req", bus_req, 0);
    chk("rstb_alu_wb", ALU_wb, 0);
    chk("rstb_inst3_wb", inst3_wb, 0);
    chk("rstb_m2r_wb", MemtoReg_wb, 0);
    chk("rstb_rdata_wb", rdata_wb, 0);
    @(negedge clk);
    MemWrite = 0;
    rst_n = 1'b1;
    #1;
    chk("rstb_stall", stall, 0);
    run(0, 0, 1, 1, 32'h77, 0, 5'd2, 3'b000, 0, 0);
    for (int i = 0; i < 400; i++) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 3);
      a = ($urandom_range(0, 1) == 1) ? ($urandom & ~32'h3) : $urandom;
      run(k == 1 || k == 3, k == 2 || k == 3, 1'($urandom), 1'($urandom), a, $urandom,
          5'($urandom), 3'($urandom), $urandom_range(0, 3), $urandom);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
